ab_stimulus_driver: RTL

- Command-driven initiator for the two-input (a, b) state-machine interface.
- Accepts queued commands, each holding an (a, b) value, a hold length and an optional expected-state check.
- Drives a/b into a downstream state machine for the programmed number of clock edges, then samples that machine's 4-bit state and compares it to the expected value.
- Records pass/fail status and an error count for on-chip self-test of the state-machine block.

---
 rtl/ab_stimulus_driver_if.sv | 24 ++
 rtl/ab_stimulus_driver.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ab_stimulus_driver_if.sv
// Command channel into ab_stimulus_driver: one queued (a, b, hold, check) request.
// The master offers commands and the slave (the driver) accepts them via cmd_ready.
interface ab_stimulus_driver_if #(
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned STATE_W = 4
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_a;
    logic               cmd_b;
    logic [CNT_W-1:0]   cmd_len;
    logic               cmd_chk;
    logic [STATE_W-1:0] cmd_exp;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_len, cmd_chk, cmd_exp,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_len, cmd_chk, cmd_exp,
        output cmd_ready
    );
endinterface

// File: rtl/ab_stimulus_driver.sv
// Command-queued a/b stimulus driver with a post-hold state check.
// It records pass/fail status for on-chip self-test of a downstream state machine.
module ab_stimulus_driver #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned STATE_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    ab_stimulus_driver_if.slave cmd,
    input  logic                clr,
    output logic                a,
    output logic                b,
    input  logic [STATE_W-1:0]  state,
    output logic                busy,
    output logic                done,
    output logic                mismatch,
    output logic [7:0]          err_count,
    output logic [STATE_W-1:0]  last_state
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic               a;
        logic               b;
        logic [CNT_W-1:0]   len;
        logic               chk;
        logic [STATE_W-1:0] exp;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} fsm_t;

    cmd_t               mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        count_q;
    logic               full, empty, push, pop;
    cmd_t               head, wr_data;

    fsm_t               fsm_q, fsm_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               chk_q, chk_d;
    logic [STATE_W-1:0] exp_q, exp_d;
    logic               a_q, a_d, b_q, b_d;
    logic               done_q, done_d;
    logic               mismatch_q, mismatch_d;
    logic [7:0]         err_q, err_d;
    logic [STATE_W-1:0] last_q, last_d;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push    = cmd.cmd_valid && !full;
    assign pop     = (fsm_q == IDLE) && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign wr_data = '{a: cmd.cmd_a, b: cmd.cmd_b, len: cmd.cmd_len,
                       chk: cmd.cmd_chk, exp: cmd.cmd_exp};

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q      <= IDLE;
            rem_q      <= '0;
            chk_q      <= 1'b0;
            exp_q      <= '0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
            err_q      <= '0;
            last_q     <= '0;
        end else begin
            fsm_q      <= fsm_d;
            rem_q      <= rem_d;
            chk_q      <= chk_d;
            exp_q      <= exp_d;
            a_q        <= a_d;
            b_q        <= b_d;
            done_q     <= done_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
            last_q     <= last_d;
        end
    end

    always_comb begin
        fsm_d      = fsm_q;
        rem_d      = rem_q;
        chk_d      = chk_q;
        exp_d      = exp_q;
        a_d        = a_q;
        b_d        = b_q;
        done_d     = 1'b0;
        mismatch_d = mismatch_q;
        err_d      = err_q;
        last_d     = last_q;

        case (fsm_q)
            IDLE: begin
                if (pop) begin
                    a_d   = head.a;
                    b_d   = head.b;
                    rem_d = (head.len == '0) ? CNT_W'(1) : head.len;
                    chk_d = head.chk;
                    exp_d = head.exp;
                    fsm_d = DRIVE;
                end
            end
            DRIVE: begin
                if (rem_q == CNT_W'(1)) fsm_d = chk_q ? CHECK : IDLE;
                else                    rem_d = rem_q - 1'b1;
            end
            CHECK: begin
                done_d = 1'b1;
                last_d = state;
                if (state != exp_q) begin
                    mismatch_d = 1'b1;
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                end
                fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase

        // clr overrides any status update from a check in the same cycle
        if (clr) begin
            mismatch_d = 1'b0;
            err_d      = '0;
            last_d     = '0;
        end
    end

    assign cmd.cmd_ready = !full;
    assign a             = a_q;
    assign b             = b_q;
    assign busy          = (fsm_q != IDLE) || !empty;
    assign done          = done_q;
    assign mismatch      = mismatch_q;
    assign err_count     = err_q;
    assign last_state    = last_q;

endmodule
